// File: rtl/ddc_acq_buf.sv
// DDC acquisition buffer: pre/post-trigger capture of {amp, phase} pairs
// into a circular RAM, then in-order readout over a valid/ready port.
module ddc_acq_buf #(
  parameter int DATA_WIDTH = 25,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [DATA_WIDTH-1:0]   amp_i,
  input  logic [DATA_WIDTH-1:0]   phase_i,
  input  logic                    val_i,
  input  logic                    arm_i,
  input  logic                    abort_i,
  input  logic                    trig_i,
  input  logic [DEPTH_LOG2:0]     num_i,
  input  logic [DEPTH_LOG2:0]     pretrig_i,
  output logic [2*DATA_WIDTH-1:0] dout_o,
  output logic                    dout_val_o,
  input  logic                    dout_rdy_i,
  output logic                    dout_last_o,
  output logic                    busy_o,
  output logic                    err_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int AW    = DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam int WW    = 2 * DATA_WIDTH;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_WAIT, S_POST, S_READ
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW-1:0]   trig_q, trig_d;
  logic [AW-1:0]   rd_addr_q, rd_addr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   num_q, num_d;
  logic [CW-1:0]   pre_q, pre_d;
  logic [CW-1:0]   left_q, left_d;
  logic            primed_q, primed_d;
  logic            err_q, err_d;

  logic [WW-1:0]   mem [DEPTH];
  logic [WW-1:0]   rdata_q;
  logic [AW-1:0]   ram_raddr;
  logic            we;
  logic            arm_ok;
  logic            fire;
  logic [CW-1:0]   post_n;
  logic [CW-1:0]   cnt_inc;

  assign arm_ok  = (num_i != '0) && (num_i <= DEPTH_C)
                && (pretrig_i < num_i);
  assign post_n  = num_q - pre_q;
  assign cnt_inc = cnt_q + ONE_C;
  assign fire    = dout_val_o & dout_rdy_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      wptr_q    <= '0;
      trig_q    <= '0;
      rd_addr_q <= '0;
      cnt_q     <= '0;
      num_q     <= '0;
      pre_q     <= '0;
      left_q    <= '0;
      primed_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wptr_q    <= wptr_d;
      trig_q    <= trig_d;
      rd_addr_q <= rd_addr_d;
      cnt_q     <= cnt_d;
      num_q     <= num_d;
      pre_q     <= pre_d;
      left_q    <= left_d;
      primed_q  <= primed_d;
      err_q     <= err_d;
    end
  end

  // Sample RAM: no reset, read port re-reads while stalled
  always_ff @(posedge clk_i) begin
    if (we) mem[wptr_q] <= {amp_i, phase_i};
    rdata_q <= mem[ram_raddr];
  end

  always_comb begin
    state_d   = state_q;
    trig_d    = trig_q;
    rd_addr_d = rd_addr_q;
    cnt_d     = cnt_q;
    num_d     = num_q;
    pre_d     = pre_q;
    left_d    = left_q;
    primed_d  = primed_q;
    err_d     = 1'b0;
    ram_raddr = rd_addr_q;
    we        = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (arm_i) begin
          if (arm_ok) begin
            num_d   = num_i;
            pre_d   = pretrig_i;
            cnt_d   = '0;
            state_d = (pretrig_i == '0) ? S_WAIT : S_PRE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_PRE: begin
        we = val_i;
        if (val_i) begin
          cnt_d = cnt_inc;
          if (cnt_inc == pre_q) state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        we = val_i;
        if (trig_i) begin
          trig_d = wptr_q;
          cnt_d  = val_i ? ONE_C : '0;
          if (val_i && post_n == ONE_C) begin
            state_d   = S_READ;
            rd_addr_d = wptr_q - pre_q[AW-1:0];
            left_d    = num_q;
            primed_d  = 1'b0;
          end else begin
            state_d = S_POST;
          end
        end
      end
      S_POST: begin
        we = val_i;
        if (val_i) begin
          cnt_d = cnt_inc;
          if (cnt_inc == post_n) begin
            state_d   = S_READ;
            rd_addr_d = trig_q - pre_q[AW-1:0];
            left_d    = num_q;
            primed_d  = 1'b0;
          end
        end
      end
      S_READ: begin
        if (!primed_q) begin
          primed_d = 1'b1;
        end else if (fire) begin
          if (left_q == ONE_C) begin
            state_d  = S_IDLE;
            primed_d = 1'b0;
          end else begin
            rd_addr_d = rd_addr_q + 1'b1;
            ram_raddr = rd_addr_q + 1'b1;
            left_d    = left_q - ONE_C;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (abort_i) begin
      state_d  = S_IDLE;
      primed_d = 1'b0;
      err_d    = 1'b0;
      we       = 1'b0;
    end
  end

  always_comb begin
    wptr_d = wptr_q;
    if (state_q == S_IDLE && arm_i && arm_ok && !abort_i)
      wptr_d = '0;
    else if (we)
      wptr_d = wptr_q + 1'b1;
  end

  always_comb begin
    busy_o      = (state_q != S_IDLE);
    dout_val_o  = (state_q == S_READ) && primed_q;
    dout_last_o = dout_val_o && (left_q == ONE_C);
    dout_o      = dout_val_o ? rdata_q : '0;
    err_o       = err_q;
  end

endmodule

// File: tb/tb_ddc_acq_buf.sv
// Randomized bench for ddc_acq_buf against a sample-history reference
// model; DEPTH_LOG2=4.
module tb_ddc_acq_buf;

  localparam int DW = 25;
  localparam int DL = 4;
  localparam int CW = DL + 1;
  localparam int WW = 2 * DW;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic [DW-1:0] amp_i = '0;
  logic [DW-1:0] phase_i = '0;
  logic          val_i = 1'b0;
  logic          arm_i = 1'b0;
  logic          abort_i = 1'b0;
  logic          trig_i = 1'b0;
  logic [CW-1:0] num_i = '0;
  logic [CW-1:0] pretrig_i = '0;
  logic [WW-1:0] dout_o;
  logic          dout_val_o;
  logic          dout_rdy_i = 1'b0;
  logic          dout_last_o;
  logic          busy_o;
  logic          err_o;

  ddc_acq_buf #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .amp_i(amp_i), .phase_i(phase_i), .val_i(val_i),
    .arm_i(arm_i), .abort_i(abort_i), .trig_i(trig_i),
    .num_i(num_i), .pretrig_i(pretrig_i),
    .dout_o(dout_o), .dout_val_o(dout_val_o),
    .dout_rdy_i(dout_rdy_i), .dout_last_o(dout_last_o),
    .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model: 0 idle, 1 pre, 2 wait trig, 3 post, 4 readout
  int            m_phase = 0;
  int            m_num, m_pre, m_trig;
  logic [WW-1:0] hist[$];
  logic [WW-1:0] exp_q[$];

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic model_step(input bit v, input bit t,
                            input logic [WW-1:0] w);
    int old;
    old = m_phase;
    case (m_phase)
      1: if (v) begin
        hist.push_back(w);
        if (hist.size() == m_pre) m_phase = 2;
      end
      2: begin
        if (t) begin
          m_trig  = hist.size();
          m_phase = 3;
        end
        if (v) hist.push_back(w);
      end
      3: if (v) hist.push_back(w);
      default: ;
    endcase
    if (m_phase == 3 && hist.size() - m_trig == m_num - m_pre)
      m_phase = 4;
    if (m_phase == 4 && old != 4) begin
      exp_q.delete();
      for (int i = 0; i < m_num; i++)
        exp_q.push_back(hist[m_trig - m_pre + i]);
    end
  endtask

  task automatic capture(input int num, input int pre,
                         input int vper, input int trig_after,
                         input int early, input bit abort_post,
                         input bit ramp);
    int n, c;
    bit v, t;
    logic [WW-1:0] w;
    arm_i = 1'b1;
    num_i = CW'(num);
    pretrig_i = CW'(pre);
    cyc();
    arm_i = 1'b0;
    m_num = num;
    m_pre = pre;
    m_phase = (pre == 0) ? 2 : 1;
    hist.delete();
    check("busy_arm", busy_o, 1);
    n = 0;
    c = 0;
    while (m_phase != 4 && c < 3000) begin
      v = (c % vper) == 0;
      t = 0;
      if (m_phase == 2 && n >= trig_after && v) t = 1;
      if (m_phase == 1 && n == early) t = 1;
      if (m_phase == 3 && $urandom % 4 == 0) t = 1;
      if (ramp) w = {DW'(n + 1), DW'(n + 1)};
      else w = {DW'($urandom), DW'($urandom)};
      val_i = v;
      trig_i = t;
      {amp_i, phase_i} = w;
      if (abort_post && m_phase == 3) begin
        abort_i = 1'b1;
        cyc();
        abort_i = 1'b0;
        val_i = 1'b0;
        trig_i = 1'b0;
        check("abort_busy", busy_o, 0);
        check("abort_val", dout_val_o, 0);
        m_phase = 0;
        return;
      end
      model_step(v, t, w);
      cyc();
      if (v) n++;
      c++;
    end
    val_i = 1'b0;
    trig_i = 1'b0;
    if (m_phase != 4) check("cap_timeout", 0, 1);
  endtask

  task automatic readout(input int mode, input int first_amp,
                         input int rst_at);
    int k, c;
    bit rdy, stalled;
    logic [WW:0] held;
    bit [3:0] pat;
    pat = 4'b1001;
    k = 0;
    c = 0;
    stalled = 0;
    held = '0;
    while (k < m_num && c < 2000) begin
      if (mode == 0) rdy = 1;
      else if (mode == 1) rdy = pat[3 - (c % 4)];
      else rdy = $urandom % 2;
      dout_rdy_i = rdy;
      if (rst_at > 0 && k == rst_at) begin
        rst_i = 1'b1;
        cyc();
        rst_i = 1'b0;
        dout_rdy_i = 1'b0;
        check("rst_val", dout_val_o, 0);
        check("rst_dout", dout_o, 0);
        check("rst_last", dout_last_o, 0);
        check("rst_busy", busy_o, 0);
        m_phase = 0;
        return;
      end
      if (mode == 0 && k > 0) check("rate", dout_val_o, 1);
      if (stalled) check("val_hold", dout_val_o, 1);
      if (dout_val_o) begin
        if (stalled) check("hold", {dout_last_o, dout_o}, held);
        if (rdy) begin
          check("word", dout_o, exp_q[k]);
          check("last", dout_last_o, k == m_num - 1);
          if (k == 0 && first_amp >= 0)
            check("first_amp", dout_o[WW-1:DW], first_amp);
          k++;
          stalled = 0;
        end else begin
          stalled = 1;
          held = {dout_last_o, dout_o};
        end
      end
      cyc();
      c++;
    end
    dout_rdy_i = 1'b0;
    if (k < m_num) check("rd_timeout", k, m_num);
    check("val_drop", dout_val_o, 0);
    check("busy_end", busy_o, 0);
    m_phase = 0;
  endtask

  task automatic bad_arm(input int num, input int pre);
    arm_i = 1'b1;
    num_i = CW'(num);
    pretrig_i = CW'(pre);
    cyc();
    arm_i = 1'b0;
    check("err_pulse", err_o, 1);
    check("err_busy", busy_o, 0);
    cyc();
    check("err_once", err_o, 0);
    check("err_busy2", busy_o, 0);
  endtask

  initial begin
    int num, pre;
    rst_i = 1'b1;
    cyc();
    cyc();
    rst_i = 1'b0;
    check("rst_dout", dout_o, 0);
    check("rst_val", dout_val_o, 0);
    check("rst_last", dout_last_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_err", err_o, 0);

    capture(8, 3, 1, 5, -1, 0, 1);
    readout(0, 3, 0);

    capture(16, 15, 1, 20, 5, 0, 1);
    readout(0, 6, 0);

    capture(10, 4, 1, 7, -1, 0, 0);
    readout(1, -1, 0);

    bad_arm(17, 0);
    bad_arm(4, 4);
    bad_arm(0, 0);

    capture(8, 2, 1, 4, -1, 1, 0);
    capture(6, 2, 2, 3, -1, 0, 0);
    readout(2, -1, 0);

    capture(12, 5, 1, 9, -1, 0, 0);
    readout(1, -1, 2);
    capture(5, 1, 1, 2, -1, 0, 1);
    readout(0, 2, 0);

    capture(4, 0, 50, 1, -1, 0, 1);
    readout(0, 2, 0);

    capture(1, 0, 1, 3, -1, 0, 0);
    readout(0, -1, 0);

    for (int i = 0; i < 6; i++) begin
      num = $urandom_range(1, 16);
      pre = $urandom_range(0, num - 1);
      capture(num, pre, $urandom_range(1, 3),
              $urandom_range(0, 20), -1, 0, 0);
      readout(2, -1, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ddc_acq_buf.md
DDC_ACQ_BUF -- requirements
Module: ddc_acq_buf

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 25, width of the amplitude and phase words received from the DDC.
REQ-002 SHALL have parameter DEPTH_LOG2, default 10; buffer depth is DEPTH = 2^DEPTH_LOG2 sample pairs.
REQ-003 Ports (one clock; reset is synchronous and active-high):
- clk_i  in  1  sole clock.
- rst_i  in  1  synchronous active-high reset.
- amp_i  in  DATA_WIDTH  DDC amplitude.
- phase_i  in  DATA_WIDTH  DDC phase.
- val_i  in  1  amp_i/phase_i valid strobe (DDC val_o).
- arm_i  in  1  one-cycle pulse; starts an acquisition.
- abort_i  in  1  one-cycle pulse; cancels any activity.
- trig_i  in  1  one-cycle trigger pulse.
- num_i  in  DEPTH_LOG2+1  total samples to capture; latched at arm.
- pretrig_i  in  DEPTH_LOG2+1  pre-trigger samples; latched at arm.
- dout_o  out  2*DATA_WIDTH  readout word {amp, phase}.
- dout_val_o  out  1  readout valid.
- dout_rdy_i  in  1  readout ready.
- dout_last_o  out  1  marks the final readout word.
- busy_o  out  1  high in any state other than IDLE.
- err_o  out  1  one-cycle pulse on a rejected arm.

Function
REQ-004 FSM states SHALL be IDLE, PRE, WAIT_TRIG, POST and READ.
REQ-005 IDLE->PRE on arm_i only if 1 <= num_i <= DEPTH and pretrig_i < num_i. Otherwise the block SHALL stay in IDLE and pulse err_o the next cycle.
REQ-006 On an accepted arm, the block SHALL reset the write pointer and pre-trigger counter to 0; if pretrig_i = 0 it SHALL go directly to WAIT_TRIG.
REQ-007 In PRE, WAIT_TRIG and POST, each cycle with val_i=1 SHALL write {amp_i, phase_i} at the write pointer and increment it modulo DEPTH (wrap-around).
REQ-008 PRE SHALL count written samples and go to WAIT_TRIG once the count reaches pretrig; trig_i during PRE SHALL be ignored.
REQ-009 WAIT_TRIG->POST on trig_i. The trigger address SHALL be the current write pointer.
REQ-010 A sample with val_i=1 in the trigger cycle SHALL be written and SHALL count as the first post-trigger sample.
REQ-011 POST SHALL capture num-pretrig post-trigger samples (including the trigger-cycle sample), then go to READ; trig_i in POST SHALL be ignored.
REQ-012 READ start address SHALL be (trigger address - pretrig) mod DEPTH; words SHALL be emitted in capture order, exactly num words.
REQ-013 Buffer SHALL be synchronous-read RAM with 1-cycle read latency; a prefetch/output register SHALL allow sustained 1 word/cycle when dout_rdy_i=1.
REQ-014 Handshake: a word transfers when dout_val_o & dout_rdy_i. While dout_val_o=1 and dout_rdy_i=0, dout_o, dout_val_o and dout_last_o SHALL hold stable.
REQ-015 dout_last_o SHALL be 1 only with the num-th word. After that word transfers, the FSM SHALL go to IDLE and dout_val_o SHALL drop the next cycle.
REQ-016 abort_i in any state SHALL go to IDLE the next cycle and deassert dout_val_o; abort_i has priority over arm_i, trig_i and val_i in the same cycle.
REQ-017 arm_i outside IDLE SHALL be ignored without err_o; val_i in IDLE and READ SHALL be ignored.
REQ-018 Samples are stored bit-exact; no arithmetic is applied to the data.

Reset
REQ-019 With rst_i=1 at a clock edge, the block SHALL enter IDLE and clear all pointers and counters. It SHALL drive dout_o=0, dout_val_o=0, dout_last_o=0, busy_o=0 and err_o=0.
REQ-020 Reset SHALL take effect mid-acquisition or mid-readout with the same result. RAM contents need no reset.

Verification (DEPTH_LOG2=4)
REQ-021 num=8, pretrig=3, data ramp 1,2,3,... on every val_i, trig after the 5th sample -> readout 3,4,5,6,7,8,9,10 with last on 10.
REQ-022 num=16, pretrig=15, trig issued during PRE -> trig ignored; next trig after the 20th sample -> readout 6..21 (pointer wrap), last on 21.
REQ-023 Readout with dout_rdy_i toggling 1,0,0,1 -> no word lost or duplicated, dout_o stable while stalled, 1 word/cycle when rdy is held high.
REQ-024 arm with num=17, or with pretrig=num=4 -> err_o single pulse, busy_o stays 0.
REQ-025 abort_i in POST, and rst_i mid-READ -> IDLE next cycle, dout_val_o=0; a subsequent arm yields a correct new capture.
REQ-026 val_i asserted only every 50th cycle (CIC rate), num=4, pretrig=0, trig coincident with val_i -> that sample is the first word read out.
